// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencing controller:
// state encoding, recognised opcodes, ALUOp selectors and error codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_IALU) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter shared by the instruction fetch and data access phases.
// Counts cycles where a request is pending without ready; timeout is raised
// in the cycle that would bring the count to LIMIT. LIMIT = 0 never times out.
module mem_wait_timer #(
    parameter int LIMIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic timeout
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // Stall count: cleared on ready or phase change, advanced while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (LIMIT != 0) && en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the RV32I datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB with req/ready
// memory handshakes. Optional performance counters under `PERF_CNT_EN`.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int STALL_LIMIT = 0,
    parameter int PERF_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        halted,
    output logic [1:0]  err
`ifdef PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    state_t     state, state_nx;
    logic [6:0] opcode_q;
    logic [1:0] err_nx;
    logic       wait_en, wait_clr, timeout;
    logic       unused_funct3;

    // Only funct3[0] distinguishes BEQ from BNE; the other bits are not needed.
    assign unused_funct3 = ^funct3[2:1];

    assign wait_en  = ((state == S_FETCH) && run && !imem_ready) ||
                      ((state == S_MEM) && !dmem_ready);
    assign wait_clr = ((state == S_MEM) ? dmem_ready : imem_ready) || (state_nx != state);

    mem_wait_timer #(.LIMIT(STALL_LIMIT)) u_wait (
        .clk     (clk),
        .reset   (reset),
        .en      (wait_en),
        .clr     (wait_clr),
        .timeout (timeout)
    );

    // State and sticky error register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            err   <= ERR_NONE;
        end else begin
            state <= state_nx;
            err   <= err_nx;
        end
    end

    // Capture the opcode while in DECODE so later phases see a stable copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q <= '0;
        end else if (state == S_DECODE) begin
            opcode_q <= opcode;
        end
    end

    // Next-state and control decode; everything forced low while in reset.
    always_comb begin
        state_nx   = state;
        err_nx     = err;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALUOP_ADD;
        halted     = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        imem_req = 1'b1;
                        if (imem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                            state_nx = S_DECODE;
                        end else if (timeout) begin
                            err_nx   = ERR_TIMEOUT;
                            state_nx = S_HALT;
                        end
                    end
                end
                S_DECODE: begin
                    if (is_legal(opcode)) begin
                        state_nx = S_EXEC;
                    end else begin
                        err_nx   = ERR_ILLEGAL;
                        state_nx = S_HALT;
                    end
                end
                S_EXEC: begin
                    case (opcode_q)
                        OP_RTYPE: begin
                            alu_op   = ALUOP_FUNCT;
                            state_nx = S_WB;
                        end
                        OP_IALU: begin
                            alu_src  = 1'b1;
                            alu_op   = ALUOP_FUNCT;
                            state_nx = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src  = 1'b1;
                            alu_op   = ALUOP_ADD;
                            state_nx = S_MEM;
                        end
                        OP_BRANCH: begin
                            alu_op = ALUOP_SUB;
                            if (zero ^ funct3[0]) begin
                                pc_write = 1'b1;
                                pc_sel   = 1'b1;
                            end
                            state_nx = S_FETCH;
                        end
                        default: state_nx = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    mem_read  = (opcode_q == OP_LOAD);
                    mem_write = (opcode_q == OP_STORE);
                    if (dmem_ready) begin
                        state_nx = (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
                    end else if (timeout) begin
                        err_nx   = ERR_TIMEOUT;
                        state_nx = S_HALT;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode_q == OP_LOAD);
                    state_nx   = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_nx = S_HALT;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Cycle and retired-instruction counters; both wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_HALT) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if ((state == S_EXEC || state == S_MEM || state == S_WB) && state_nx == S_FETCH) begin
                instret_cnt <= instret_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (STALL_LIMIT = 4). Expected
// per-cycle control outputs are generated from the instruction-level rules:
// each instruction expands into a list of cycles with the inputs to drive
// and the outputs that must appear. Unconstrained inputs are randomised.
module tb_multicycle_ctrl;

    localparam int STALL = 4;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_ST  = 7'b0100011;
    localparam logic [6:0] T_BR  = 7'b1100011;

    // Bit positions in the packed output vector.
    localparam int B_IREQ = 14, B_DREQ = 13, B_IRW = 12, B_PCW = 11, B_PCSEL = 10;
    localparam int B_REGW = 9, B_MRD = 8, B_MWR = 7, B_M2R = 6, B_ASRC = 5;
    localparam int B_AOP  = 3, B_HALT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, ir_write, pc_write, pc_sel, reg_write;
    logic mem_read, mem_write, mem_to_reg, alu_src, halted;
    logic [1:0] alu_op, err;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt, cyc_s, ret_s, exp_cyc, exp_ret;
`endif

    logic [14:0] obs, obs_s;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        run;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        zero;
        logic        ir;
        logic        dr;
        logic [14:0] want;
        logic        retire;
    } cyc_t;

    cyc_t q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.STALL_LIMIT(STALL), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
        .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .halted(halted), .err(err)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    assign obs = {imem_req, dmem_req, ir_write, pc_write, pc_sel, reg_write, mem_read,
                  mem_write, mem_to_reg, alu_src, alu_op, halted, err};

    function automatic logic [14:0] b(input int p);
        return 15'd1 << p;
    endfunction

    function automatic cyc_t rnd_cyc();
        cyc_t c;
        c.run    = 1'($urandom);
        c.opc    = 7'($urandom);
        c.f3     = 3'($urandom);
        c.zero   = 1'($urandom);
        c.ir     = 1'($urandom);
        c.dr     = 1'($urandom);
        c.want   = '0;
        c.retire = 1'b0;
        return c;
    endfunction

    // Reference model: expand one instruction into its expected cycles.
    task automatic add_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                             input int di, input int dd);
        cyc_t c;
        logic ld, st, br, legal;
        ld = (opc == T_LD); st = (opc == T_ST); br = (opc == T_BR);
        legal = ld || st || br || (opc == T_R) || (opc == T_I);
        for (int i = 0; i < di; i++) begin
            c = rnd_cyc(); c.run = 1'b1; c.ir = 1'b0; c.want = b(B_IREQ);
            q.push_back(c);
        end
        c = rnd_cyc(); c.run = 1'b1; c.ir = 1'b1; c.want = b(B_IREQ) | b(B_IRW) | b(B_PCW);
        q.push_back(c);
        c = rnd_cyc(); c.opc = opc; c.f3 = f3; c.want = '0;
        q.push_back(c);
        if (!legal) begin
            for (int i = 0; i < 3; i++) begin
                c = rnd_cyc(); c.run = 1'b1; c.ir = 1'b1; c.want = b(B_HALT) | 15'd1;
                q.push_back(c);
            end
            return;
        end
        c = rnd_cyc(); c.f3 = f3; c.zero = z;
        if (br) begin
            c.want = 15'd1 << B_AOP;
            if (z ^ f3[0]) c.want = c.want | b(B_PCW) | b(B_PCSEL);
            c.retire = 1'b1;
        end else if (ld || st) begin
            c.want = b(B_ASRC);
        end else begin
            c.want = (15'd2 << B_AOP) | ((opc == T_I) ? b(B_ASRC) : 15'd0);
        end
        q.push_back(c);
        if (ld || st) begin
            for (int i = 0; i <= dd; i++) begin
                c = rnd_cyc(); c.f3 = f3; c.dr = (i == dd);
                c.want = b(B_DREQ) | (ld ? b(B_MRD) : b(B_MWR));
                c.retire = st && (i == dd);
                q.push_back(c);
            end
        end
        if (!br && !st) begin
            c = rnd_cyc(); c.want = b(B_REGW) | (ld ? b(B_M2R) : 15'd0); c.retire = 1'b1;
            q.push_back(c);
        end
    endtask

    task automatic add_idle(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = rnd_cyc(); c.run = 1'b0; c.want = '0;
            q.push_back(c);
        end
    endtask

    // Apply one cycle of inputs just after a falling edge and sample outputs.
    task automatic drive(input cyc_t c);
        run = c.run; opcode = c.opc; funct3 = c.f3; zero = c.zero;
        imem_ready = c.ir; dmem_ready = c.dr;
        #1;
        obs_s = obs;
`ifdef PERF_CNT_EN
        cyc_s = cycle_cnt; ret_s = instret_cnt;
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
`ifdef PERF_CNT_EN
        exp_cyc = '0; exp_ret = '0;
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = T_R;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== 15'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got=%b want=%b", i, obs, 15'd0);
            end
`ifdef PERF_CNT_EN
            checks++;
            if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
                errors++;
                $display("FAIL reset_counters got=%0d/%0d want=0/0", cycle_cnt, instret_cnt);
            end
`endif
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    task automatic test_rtype();
        cyc_t c; int n = 0;
        do_reset();
        add_instr(T_R, 3'd0, 1'b0, 0, 0);
        add_instr(T_I, 3'd0, 1'b0, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++;
            if (obs_s !== c.want) begin
                errors++;
                $display("FAIL rtype cyc%0d got=%b want=%b", n, obs_s, c.want);
            end
            n++;
        end
    endtask

    task automatic test_load_wait();
        cyc_t c; int n = 0;
        do_reset();
        add_instr(T_LD, 3'd2, 1'b0, 0, 3);
        add_instr(T_ST, 3'd2, 1'b0, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++;
            if (obs_s !== c.want) begin
                errors++;
                $display("FAIL load_wait cyc%0d got=%b want=%b", n, obs_s, c.want);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        cyc_t c; int n = 0;
        do_reset();
        add_instr(T_BR, 3'b000, 1'b1, 0, 0);
        add_instr(T_BR, 3'b001, 1'b1, 0, 0);
        add_instr(T_BR, 3'b001, 1'b0, 1, 0);
        add_instr(T_R, 3'd0, 1'b0, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++;
            if (obs_s !== c.want) begin
                errors++;
                $display("FAIL branch cyc%0d got=%b want=%b", n, obs_s, c.want);
            end
            n++;
        end
    endtask

    task automatic test_random();
        cyc_t c; int n = 0;
        logic [6:0] ops [5];
        ops[0] = T_R; ops[1] = T_I; ops[2] = T_LD; ops[3] = T_ST; ops[4] = T_BR;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) add_idle(int'($urandom_range(1, 2)));
            add_instr(ops[$urandom_range(0, 4)], 3'($urandom), 1'($urandom),
                      int'($urandom_range(0, STALL - 1)), int'($urandom_range(0, STALL - 1)));
        end
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++;
            if (obs_s !== c.want) begin
                errors++;
                $display("FAIL random cyc%0d got=%b want=%b", n, obs_s, c.want);
            end
`ifdef PERF_CNT_EN
            checks++;
            if (cyc_s !== exp_cyc || ret_s !== exp_ret) begin
                errors++;
                $display("FAIL random_counters cyc%0d got=%0d/%0d want=%0d/%0d",
                         n, cyc_s, ret_s, exp_cyc, exp_ret);
            end
            if (!c.want[B_HALT]) exp_cyc = exp_cyc + 1;
            if (c.retire) exp_ret = exp_ret + 1;
`endif
            n++;
        end
    endtask

    task automatic test_illegal();
        cyc_t c; int n = 0;
        do_reset();
        add_instr(T_R, 3'd0, 1'b0, 0, 0);
        add_instr(7'b1111111, 3'd0, 1'b0, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++;
            if (obs_s !== c.want) begin
                errors++;
                $display("FAIL illegal cyc%0d got=%b want=%b", n, obs_s, c.want);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        cyc_t c; int n = 0;
        do_reset();
        for (int i = 0; i < STALL; i++) begin
            c = rnd_cyc(); c.run = 1'b1; c.ir = 1'b0; c.want = b(B_IREQ);
            q.push_back(c);
        end
        for (int i = 0; i < 3; i++) begin
            c = rnd_cyc(); c.run = 1'b1; c.ir = 1'b1; c.want = b(B_HALT) | 15'd2;
            q.push_back(c);
        end
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++;
            if (obs_s !== c.want) begin
                errors++;
                $display("FAIL timeout cyc%0d got=%b want=%b", n, obs_s, c.want);
            end
`ifdef PERF_CNT_EN
            checks++;
            if (cyc_s !== exp_cyc) begin
                errors++;
                $display("FAIL timeout_cycles cyc%0d got=%0d want=%0d", n, cyc_s, exp_cyc);
            end
            if (!c.want[B_HALT]) exp_cyc = exp_cyc + 1;
`endif
            n++;
        end
    endtask

    task automatic test_reset_mid_mem();
        cyc_t c; int n = 0;
        do_reset();
        add_instr(T_LD, 3'd2, 1'b0, 0, 3);
        for (int i = 0; i < 5; i++) begin
            c = q.pop_front(); drive(c); checks++;
            if (obs_s !== c.want) begin
                errors++;
                $display("FAIL pre_reset cyc%0d got=%b want=%b", i, obs_s, c.want);
            end
        end
        q.delete();
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; opcode = T_LD;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL mid_mem_reset got=%b want=%b", obs, 15'd0);
        end
`ifdef PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_mem_counters got=%0d/%0d want=0/0", cycle_cnt, instret_cnt);
        end
        exp_cyc = '0; exp_ret = '0;
`endif
        @(negedge clk);
        reset = 1'b1;
        add_instr(T_R, 3'd0, 1'b0, STALL - 1, 0);
        add_instr(T_LD, 3'd2, 1'b0, 0, STALL - 1);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++;
            if (obs_s !== c.want) begin
                errors++;
                $display("FAIL post_reset cyc%0d got=%b want=%b", n, obs_s, c.want);
            end
`ifdef PERF_CNT_EN
            checks++;
            if (cyc_s !== exp_cyc || ret_s !== exp_ret) begin
                errors++;
                $display("FAIL post_reset_counters cyc%0d got=%0d/%0d want=%0d/%0d",
                         n, cyc_s, ret_s, exp_cyc, exp_ret);
            end
            if (!c.want[B_HALT]) exp_cyc = exp_cyc + 1;
            if (c.retire) exp_ret = exp_ret + 1;
`endif
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the RV32I datapath (PC, instruction memory, register file, ALU, data memory).
- Replaces the single-cycle `Control` decode with a state machine. One instruction executes over 3–5 states.
- Instruction and data memory accesses use a req/ready handshake, so the datapath tolerates wait-stated memories.
- Sits beside the datapath. Drives its write enables, mux selects and ALUOp. Receives opcode, funct3 and the ALU `zero` flag.

Parameters:
- STALL_LIMIT, 0, max cycles a memory req may wait for ready; 0 = wait forever.
- PERF_W, 32, width of the performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  fetch permitted when 1.
- opcode  in  7  instruction[6:0] from the IR.
- funct3  in  3  instruction[14:12].
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction memory ready.
- dmem_ready  in  1  data memory ready.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- ir_write  out  1  latch instruction into the IR.
- pc_write  out  1  update PC this cycle.
- pc_sel  out  1  0 = PC+4, 1 = PC+imm.
- reg_write  out  1  register file write enable.
- mem_read  out  1  data read.
- mem_write  out  1  data write.
- mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory.
- alu_src  out  1  ALU operand B: 0 = rs2, 1 = imm.
- alu_op  out  2  00 = add, 01 = sub (branch), 10 = funct-decoded.
- halted  out  1  controller in HALT.
- err  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- cycle_cnt  out  PERF_W  cycles since reset (PERF_CNT_EN only).
- instret_cnt  out  PERF_W  retired instructions (PERF_CNT_EN only).

Behaviour:
- Reset (reset = 0, async):
  - State = FETCH, opcode_q = 0, err = 00, wait counter = 0.
  - All outputs 0; counters 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is in the package.
- Outputs are Moore, decoded from state and opcode_q.
  - Exception: imem_req and dmem_req are held high while waiting; ir_write and pc_write pulse in the ready cycle.
- FETCH:
  - If run = 0: idle, no req.
  - Else: imem_req = 1.
  - When imem_ready = 1 (sampled the same cycle): ir_write = 1, pc_write = 1, pc_sel = 0, then go to DECODE.
- DECODE:
  - Latch opcode_q <= opcode.
  - Legal opcodes: 0110011 (R-type), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch).
  - Legal opcode: go to EXEC. Any other opcode: err = 01, go to HALT.
- EXEC by opcode:
  - R-type: alu_src = 0, alu_op = 10, go to WB.
  - I-ALU: alu_src = 1, alu_op = 10, go to WB.
  - Load/store: alu_src = 1, alu_op = 00, go to MEM.
  - Branch: alu_src = 0, alu_op = 01.
    - taken = zero XOR funct3[0] (BEQ/BNE).
    - If taken: pc_write = 1, pc_sel = 1.
    - Go to FETCH.
- Branch target: the datapath uses the PC of the branch held in an old-PC register, so the FETCH PC+4 is not double-counted. This requirement is on the datapath.
- MEM:
  - dmem_req = 1, with mem_read (load) or mem_write (store) held until dmem_ready = 1.
  - Then load goes to WB; store goes to FETCH.
- WB: reg_write = 1. mem_to_reg = 1 for load, else 0. Go to FETCH.
- Latency with zero-wait memory: R-type/I-ALU 4 cycles, load 5, store 4, branch 3.
- Wait counter:
  - Counts cycles with req high and ready low; clears on ready or on a state change.
  - If STALL_LIMIT ≠ 0 and count reaches STALL_LIMIT: err = 10, drop req, go to HALT.
- HALT: all enables 0, halted = 1. Exit only via reset.
- run deasserted mid-instruction does not abort; it is checked only in FETCH.
- Reset mid-handshake: req drops immediately (async). Memory must tolerate an abandoned request.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle out of reset, except in HALT.
  - instret_cnt increments on every transition into FETCH from EXEC, MEM or WB.
  - Both wrap modulo 2^PERF_W.
- Undefined: cycle_cnt and instret_cnt ports are absent; no counter logic.

Decomposition:
- Package `cpu_ctrl_pkg` holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALUOp constants;
  - err codes.
- One sub-module, `mem_wait_timer`: the STALL_LIMIT wait counter with clear/enable and a timeout output. Instantiated once and shared by FETCH and MEM.

Test Plan:
- R-type add, zero-wait memory, run = 1: states FETCH→DECODE→EXEC→WB in 4 cycles; reg_write high in cycle 4 only; alu_op = 10.
- Load with dmem_ready delayed 3 cycles: dmem_req and mem_read held 4 cycles; WB has mem_to_reg = 1; total 8 cycles.
- BEQ with zero = 1, then BNE with zero = 1: first sets pc_write = 1, pc_sel = 1 in EXEC; second sets pc_write = 0; each takes 3 cycles.
- Opcode 1111111: err = 01 and halted = 1 in the cycle after DECODE; stays there until reset.
- STALL_LIMIT = 4, imem_ready stuck at 0: imem_req high for 4 cycles, then err = 10, halted = 1.
- Async reset pulled low mid-MEM: all outputs 0 immediately; after release with run = 1, FETCH restarts. With PERF_CNT_EN, both counters read 0.
